oled_seq_ctrl: RTL and testbench

OLED_SEQ_CTRL -- requirements
Module: oled_seq_ctrl

---
 rtl/oled_seq_ctrl_pkg.sv | 25 ++
 rtl/oled_seq_ctrl_if.sv | 31 +++
 rtl/oled_seq_ctrl_init_rom.sv | 44 ++++
 rtl/oled_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_oled_seq_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/oled_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// oled_pkg: shared state encoding and constants for oled_seq_ctrl.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package oled_pkg;
  typedef enum logic [2:0] {
    PWR_HI1  = 3'd0,
    PWR_LO   = 3'd1,
    PWR_HI2  = 3'd2,
    INIT     = 3'd3,
    GAP      = 3'd4,
    FETCH    = 3'd5,
    SEND_PIX = 3'd6,
    SEND_CMD = 3'd7
  } state_t;

  localparam int   FRAME_BYTES = 1024;
  localparam int   INIT_LEN    = 23;
  localparam logic DC_CMD      = 1'b0;
  localparam logic DC_DATA     = 1'b1;
endpackage

`default_nettype wire

// File: rtl/oled_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// oled_seq_ctrl_if: SPI byte stream, frame-buffer read and runtime command bus.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface oled_seq_ctrl_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       pix_req;
  logic [9:0] pix_addr;
  logic [7:0] pix_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       frame_start;

  modport master (
    output tx_valid, tx_byte, tx_dc, pix_req, pix_addr, cmd_ready, frame_start,
    input  tx_ready, pix_data, cmd_valid, cmd_data
  );

  modport slave (
    input  tx_valid, tx_byte, tx_dc, pix_req, pix_addr, cmd_ready, frame_start,
    output tx_ready, pix_data, cmd_valid, cmd_data
  );
endinterface

`default_nettype wire

// File: rtl/oled_seq_ctrl_init_rom.sv
// ----------------------------------------------------------------------------
// oled_init_rom: combinational panel init command table (index -> byte).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic [7:0] o_data
);
  always_comb begin
    o_data = 8'h00;
    case (i_idx)
      5'd0:  o_data = 8'hAE;
      5'd1:  o_data = 8'h81;
      5'd2:  o_data = 8'h7F;
      5'd3:  o_data = 8'hA6;
      5'd4:  o_data = 8'h20;
      5'd5:  o_data = 8'h00;
      5'd6:  o_data = 8'hC8;
      5'd7:  o_data = 8'h40;
      5'd8:  o_data = 8'hA1;
      5'd9:  o_data = 8'hA8;
      5'd10: o_data = 8'h3F;
      5'd11: o_data = 8'hD3;
      5'd12: o_data = 8'h00;
      5'd13: o_data = 8'hD5;
      5'd14: o_data = 8'h80;
      5'd15: o_data = 8'hD9;
      5'd16: o_data = 8'h22;
      5'd17: o_data = 8'hDB;
      5'd18: o_data = 8'h20;
      5'd19: o_data = 8'h8D;
      5'd20: o_data = 8'h14;
      5'd21: o_data = 8'hA4;
      5'd22: o_data = 8'hAF;
      default: o_data = 8'h00;
    endcase
  end
endmodule

`default_nettype wire

// File: rtl/oled_seq_ctrl.sv
// ----------------------------------------------------------------------------
// oled_seq_ctrl: panel power-up, init stream and continuous frame refresh.
// Define OLED_SEQ_CTRL_CMD_EN to service runtime commands at frame gaps.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module oled_seq_ctrl #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
  parameter int          FRAME_BYTES  = 1024,
  parameter int          INIT_LEN     = 23
) (
  input  logic            clk,
  input  logic            rst,
  oled_seq_ctrl_if.master bus,
  output logic            o_reset,
  output logic            o_cs
);
  import oled_pkg::*;

`ifdef OLED_SEQ_CTRL_CMD_EN
  localparam logic c_cmd_en = 1'b1;
`else
  localparam logic c_cmd_en = 1'b0;
`endif

  localparam logic [4:0] c_init_last  = 5'(INIT_LEN - 1);
  localparam logic [9:0] c_frame_last = 10'(FRAME_BYTES - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [9:0]  r_addr, w_addr_nxt;
  logic        r_phase, w_phase_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic [7:0]  w_rom_byte;

  oled_init_rom u_rom (
    .i_idx  (r_idx),
    .o_data (w_rom_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PWR_HI1;
      r_cnt   <= 32'd0;
      r_idx   <= 5'd0;
      r_addr  <= 10'd0;
      r_phase <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_phase <= w_phase_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign bus.pix_addr = r_addr;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_addr_nxt      = r_addr;
    w_phase_nxt     = r_phase;
    w_data_nxt      = r_data;
    bus.tx_valid    = 1'b0;
    bus.tx_byte     = 8'h00;
    bus.tx_dc       = DC_CMD;
    bus.pix_req     = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.frame_start = 1'b0;
    o_reset         = 1'b1;
    o_cs            = 1'b0;

    case (r_state)
      PWR_HI1, PWR_LO, PWR_HI2: begin
        o_cs      = 1'b1;
        o_reset   = (r_state != PWR_LO);
        w_cnt_nxt = r_cnt + 32'd1;
        if (r_cnt == STARTUP_WAIT - 32'd1) begin
          w_cnt_nxt = 32'd0;
          case (r_state)
            PWR_HI1: w_state_nxt = PWR_LO;
            PWR_LO:  w_state_nxt = PWR_HI2;
            default: w_state_nxt = INIT;
          endcase
        end
      end

      INIT: begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = w_rom_byte;
        if (bus.tx_ready) begin
          if (r_idx == c_init_last) begin
            w_idx_nxt   = 5'd0;
            w_state_nxt = GAP;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end

      GAP: begin
        w_addr_nxt  = 10'd0;
        w_phase_nxt = 1'b0;
        w_state_nxt = (c_cmd_en && bus.cmd_valid) ? SEND_CMD : FETCH;
      end

      // Phase 0 captures the command byte, phase 1 offers it to the shifter.
      SEND_CMD: begin
        if (!r_phase) begin
          bus.cmd_ready = c_cmd_en;
          if (bus.cmd_valid) begin
            w_data_nxt  = bus.cmd_data;
            w_phase_nxt = 1'b1;
          end else begin
            w_state_nxt = FETCH;
          end
        end else begin
          bus.tx_valid = 1'b1;
          bus.tx_byte  = r_data;
          if (bus.tx_ready) begin
            w_phase_nxt = 1'b0;
            w_state_nxt = FETCH;
          end
        end
      end

      // Phase 0 strobes the read, phase 1 registers the returned byte.
      FETCH: begin
        if (!r_phase) begin
          bus.pix_req = 1'b1;
          w_phase_nxt = 1'b1;
        end else begin
          w_data_nxt  = bus.pix_data;
          w_phase_nxt = 1'b0;
          w_state_nxt = SEND_PIX;
        end
      end

      SEND_PIX: begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = r_data;
        bus.tx_dc    = DC_DATA;
        if (bus.tx_ready) begin
          bus.frame_start = (r_addr == 10'd0);
          if (r_addr == c_frame_last) begin
            w_state_nxt = GAP;
          end else begin
            w_addr_nxt  = r_addr + 10'd1;
            w_state_nxt = FETCH;
          end
        end
      end

      default: w_state_nxt = PWR_HI1;
    endcase
  end
endmodule

`default_nettype wire

// File: tb/tb_oled_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_oled_seq_ctrl: scoreboard bench for oled_seq_ctrl with random back-pressure.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_oled_seq_ctrl;
  localparam logic [31:0] SW        = 32'd4;
  localparam int          INIT_N    = 23;
  localparam int          FRAME_N   = 1024;
  localparam int          CMD_SLOT  = INIT_N + FRAME_N;
  localparam int          CYC_LIMIT = 60000;

  typedef struct {
    logic       dc;
    logic [7:0] b;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_reset;
  logic o_cs;

  oled_seq_ctrl_if bus ();

  oled_seq_ctrl #(
    .STARTUP_WAIT (SW),
    .FRAME_BYTES  (FRAME_N),
    .INIT_LEN     (INIT_N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_reset (o_reset),
    .o_cs    (o_cs)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_tbl [INIT_N] = '{
    8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40, 8'hA1, 8'hA8, 8'h3F, 8'hD3,
    8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};

  exp_t q[$];
  int   errors     = 0;
  int   checks     = 0;
  int   xfer_count = 0;
  int   limit      = 0;
  bit   cmd_taken  = 1'b0;
  bit   cmd_raised = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_init();
    for (int i = 0; i < INIT_N; i++) q.push_back('{1'b0, rom_tbl[i], 1'b0});
  endfunction

  function automatic void push_pixels(input int n);
    for (int a = 0; a < n; a++) q.push_back('{1'b1, 8'(a), logic'(a == 0)});
  endfunction

  // Frame buffer: each byte holds the low 8 bits of its address, one cycle after the strobe.
  always @(posedge clk) begin
    bus.pix_data <= bus.pix_req ? bus.pix_addr[7:0] : 8'($urandom);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got byte %0h dc %0b with nothing expected", bus.tx_byte, bus.tx_dc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("xfer_byte", 32'(bus.tx_byte), 32'(e.b));
          chk("xfer_dc", 32'(bus.tx_dc), 32'(e.dc));
          chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
        end
        xfer_count++;
      end else begin
        chk("frame_start_idle", 32'(bus.frame_start), 32'd0);
      end
`ifdef OLED_SEQ_CTRL_CMD_EN
      if (bus.cmd_valid && bus.cmd_ready) cmd_taken = 1'b1;
      if (xfer_count != CMD_SLOT) chk("cmd_ready_outside_gap", 32'(bus.cmd_ready), 32'd0);
`else
      chk("cmd_ready_disabled", 32'(bus.cmd_ready), 32'd0);
`endif
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_o_reset"}, 32'(o_reset), 32'd1);
    chk({tag, "_o_cs"}, 32'(o_cs), 32'd1);
    chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    chk({tag, "_tx_byte"}, 32'(bus.tx_byte), 32'd0);
    chk({tag, "_tx_dc"}, 32'(bus.tx_dc), 32'd0);
    chk({tag, "_pix_req"}, 32'(bus.pix_req), 32'd0);
    chk({tag, "_pix_addr"}, 32'(bus.pix_addr), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
  endtask

  // Called in cycle 0 after rst release; walks cycles 0..12.
  task automatic power_seq_check();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #2;
      end
      chk($sformatf("o_reset_c%0d", c), 32'(o_reset), 32'(!(c >= 4 && c < 8)));
      chk($sformatf("o_cs_c%0d", c), 32'(o_cs), 32'(c < 12));
      chk($sformatf("tx_valid_c%0d", c), 32'(bus.tx_valid), 32'(c == 12));
    end
    chk("first_byte", 32'(bus.tx_byte), 32'hAE);
    chk("first_dc", 32'(bus.tx_dc), 32'd0);
  endtask

  task automatic run_until(input int lim);
    int budget;
    budget = 0;
    while (xfer_count < lim && budget < CYC_LIMIT) begin
      bus.tx_ready = ($urandom_range(0, 3) != 0);
`ifdef OLED_SEQ_CTRL_CMD_EN
      if (!cmd_raised && xfer_count == INIT_N + 500) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hA7;
        cmd_raised    = 1'b1;
      end
      if (cmd_taken) bus.cmd_valid = 1'b0;
`else
      bus.cmd_data = 8'($urandom);
`endif
      @(posedge clk);
      #2;
      budget++;
    end
    bus.tx_ready = 1'b0;
    if (budget >= CYC_LIMIT) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d transfers required %0d", xfer_count, lim);
    end
  endtask

  initial begin
    bus.tx_ready  = 1'b0;
    bus.cmd_data  = 8'h00;
`ifdef OLED_SEQ_CTRL_CMD_EN
    bus.cmd_valid = 1'b0;
`else
    bus.cmd_valid = 1'b1;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("por");

    push_init();
    push_pixels(FRAME_N);
`ifdef OLED_SEQ_CTRL_CMD_EN
    q.push_back('{1'b0, 8'hA7, 1'b0});
`endif
    push_pixels(FRAME_N);
    push_pixels(FRAME_N);
    push_pixels(300);
    limit = q.size();

    rst = 1'b0;
    power_seq_check();

    // Let AE go, then stall the shifter on 81 for ten cycles.
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(bus.tx_valid), 32'd1);
      chk("stall_byte", 32'(bus.tx_byte), 32'h81);
      @(posedge clk);
      #2;
    end

    run_until(limit);

    repeat (4) @(posedge clk);
    #2;
    chk("pix300_valid", 32'(bus.tx_valid), 32'd1);
    chk("pix300_byte", 32'(bus.tx_byte), 32'h2C);
    chk("pix300_dc", 32'(bus.tx_dc), 32'd1);
    chk("pix300_addr", 32'(bus.pix_addr), 32'd300);
    chk("queue_drained", 32'(q.size()), 32'd0);

    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_vals("mid_rst");
    push_init();
    limit = xfer_count + INIT_N;
    rst = 1'b0;
    power_seq_check();
    run_until(limit);

    repeat (20) @(posedge clk);
    #2;
    chk("queue_empty_end", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
